freq_sel_ctrl: RTL and testbench
================================

FREQ_SEL_CTRL -- requirements
Module: freq_sel_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 4: consecutive stable cycles a synchronized button must hold before its clean level changes.
REQ-002 Parameter HOLD_CYCLES, default 16: cycles a button stays held after its first step before auto-repeat starts.
REQ-003 Parameter REPEAT_CYCLES, default 8: auto-repeat step period in cycles.
REQ-004 Parameter RATIO_RESET, default 8'h05: div_ratio value after reset.
REQ-005 Parameter RATIO_MIN, default 8'h01, and RATIO_MAX, default 8'hFF: saturation bounds.
REQ-006 clock  input  1  single rising-edge clock for all state.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 btn_up  input  1  raw asynchronous "increase ratio" button, active-high, may bounce.
REQ-009 btn_down  input  1  raw asynchronous "decrease ratio" button, active-high, may bounce.
REQ-010 div_ratio  output  8  registered divide-ratio word feeding the LED divider stage's datain.
REQ-011 ratio_chg  output  1  one-cycle pulse in the cycle div_ratio takes a new value.
REQ-012 at_limit  output  1  registered, high while div_ratio equals RATIO_MIN or RATIO_MAX.

Function
REQ-013 Each button SHALL pass through a 2-flop synchronizer before any other logic.
REQ-014 Clean level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles; any mismatch break clears the count.
REQ-015 A per-button FSM SHALL have states IDLE, HELD, REPEAT: IDLE->HELD on clean rise (step event); HELD->REPEAT after HOLD_CYCLES (step event); in REPEAT, a step event every REPEAT_CYCLES; any state->IDLE in the cycle the clean level is low.
REQ-016 An up step SHALL increment div_ratio by 1 and a down step SHALL decrement it by 1, saturating at RATIO_MAX and RATIO_MIN; there is no wrap-around.
REQ-017 div_ratio SHALL update on the clock edge after the step event; first update comes exactly 2+DEBOUNCE_CYCLES+1 edges after the first edge sampling a stable high button.
REQ-018 Up and down step events in the same cycle SHALL cancel: no change, no ratio_chg.
REQ-019 A step blocked by saturation SHALL leave div_ratio unchanged and SHALL NOT pulse ratio_chg.
REQ-020 ratio_chg SHALL be high only in cycles where div_ratio differs from its previous-cycle value.
REQ-021 Both buttons held: each FSM runs independently; REQ-018 applies only to coincident step events.
REQ-022 RATIO_MIN <= RATIO_RESET <= RATIO_MAX is required; out-of-range parameters are a configuration error.

Reset
REQ-023 While reset is high at a clock edge: div_ratio=RATIO_RESET, ratio_chg=0, at_limit=(RATIO_RESET==RATIO_MIN or RATIO_MAX), synchronizers/clean levels=0, counters=0, FSMs=IDLE.
REQ-024 Reset asserted mid-press or mid-repeat SHALL abort immediately; after release, a still-held button SHALL be treated as a new press (full debounce, then step).

Structure
REQ-025 Package freq_sel_pkg SHALL hold the FSM state encoding (IDLE, HELD, REPEAT) and the default parameter constants.
REQ-026 Sub-module btn_debounce (synchronizer + debounce counter + clean level) SHALL be instantiated once per button; FSMs, arithmetic and outputs stay in freq_sel_ctrl.

Verification (DEBOUNCE=4, HOLD=16, REPEAT=8, defaults otherwise)
REQ-027 Reset release, no buttons, 100 cycles -> div_ratio=8'h05, ratio_chg never high, at_limit=0.
REQ-028 btn_up toggling every cycle for 10 cycles, then held high 3 cycles, then low -> no change; held 10 cycles -> div_ratio=8'h06 exactly 7 edges after stable high, one ratio_chg pulse.
REQ-029 btn_down held 60 cycles from 8'h05 -> steps to 04 at edge 7, 03 at +16, 02 at +8, 01 at +8; later steps blocked; at_limit=1; exactly 4 ratio_chg pulses.
REQ-030 Both buttons raised on the same edge, held 10 cycles -> coincident steps cancel; div_ratio stays 8'h05, no ratio_chg.
REQ-031 btn_up held through auto-repeat, reset pulsed 1 cycle mid-repeat -> div_ratio=8'h05 next cycle; next step only after full 7-edge debounce.
REQ-032 Drive the LED divider stage from div_ratio; stepping 8'h05->8'h10 -> downstream diode period changes accordingly; ratio_chg count matches step count.

Source files
------------

// File: rtl/freq_sel_pkg.sv
// Shared encodings and default constants for the frequency-select button controller.
// The step-FSM state type and the limit helper live here so the top and bench agree.
package freq_sel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HELD   = 2'd1,
        ST_REPEAT = 2'd2
    } btn_state_e;

    localparam int          DEBOUNCE_CYCLES_DEF = 4;
    localparam int          HOLD_CYCLES_DEF     = 16;
    localparam int          REPEAT_CYCLES_DEF   = 8;
    localparam logic [7:0]  RATIO_RESET_DEF     = 8'h05;
    localparam logic [7:0]  RATIO_MIN_DEF       = 8'h01;
    localparam logic [7:0]  RATIO_MAX_DEF       = 8'hFF;

    function automatic logic is_limit(input logic [7:0] val, input logic [7:0] lo,
                                      input logic [7:0] hi);
        return (val == lo) || (val == hi);
    endfunction

endpackage

// File: rtl/freq_sel_ctrl_if.sv
// Button inputs and divide-ratio outputs of the frequency-select controller.
// The master side presses buttons and observes the ratio; the slave is the controller.
interface freq_sel_ctrl_if;
    logic       btn_up;
    logic       btn_down;
    logic [7:0] div_ratio;
    logic       ratio_chg;
    logic       at_limit;

    modport master (
        output btn_up,
        output btn_down,
        input  div_ratio,
        input  ratio_chg,
        input  at_limit
    );

    modport slave (
        input  btn_up,
        input  btn_down,
        output div_ratio,
        output ratio_chg,
        output at_limit
    );
endinterface

// File: rtl/btn_debounce.sv
// 2-flop synchronizer plus stability counter producing a clean button level.
// Clean level follows the raw input 2 + DEBOUNCE_CYCLES edges after it settles; no backpressure.
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 4
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_i,
    output logic clean_o
);
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [1:0]    sync_q, sync_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          clean_q, clean_d;

    // Any cycle where the synchronized level agrees with the clean level restarts the count.
    always_comb begin
        sync_d  = {sync_q[0], btn_i};
        cnt_d   = '0;
        clean_d = clean_q;
        if (sync_q[1] != clean_q) begin
            if (cnt_q == CNT_LAST) begin
                clean_d = sync_q[1];
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            sync_q  <= '0;
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean_o = clean_q;
endmodule

// File: rtl/freq_sel_ctrl.sv
// Debounced up/down buttons with hold-then-auto-repeat stepping of a saturating divide ratio.
// Ratio moves one edge after a step event (2 + DEBOUNCE_CYCLES + 1 edges from a clean press); no backpressure.
module freq_sel_ctrl
    import freq_sel_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int         HOLD_CYCLES     = HOLD_CYCLES_DEF,
    parameter int         REPEAT_CYCLES   = REPEAT_CYCLES_DEF,
    parameter logic [7:0] RATIO_RESET     = RATIO_RESET_DEF,
    parameter logic [7:0] RATIO_MIN       = RATIO_MIN_DEF,
    parameter logic [7:0] RATIO_MAX       = RATIO_MAX_DEF
) (
    input  logic           clock,
    input  logic           reset,
    freq_sel_ctrl_if.slave bus
);
    localparam int MAXC = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
    localparam int TW   = (MAXC > 1) ? $clog2(MAXC) : 1;
    localparam logic [TW-1:0] HOLD_LAST = TW'(HOLD_CYCLES - 1);
    localparam logic [TW-1:0] REP_LAST  = TW'(REPEAT_CYCLES - 1);

    if (!((RATIO_MIN <= RATIO_RESET) && (RATIO_RESET <= RATIO_MAX))) begin : g_cfg_err
        $error("freq_sel_ctrl: RATIO_RESET outside [RATIO_MIN, RATIO_MAX]");
    end

    logic [1:0]    clean;
    logic [1:0]    step;
    btn_state_e    state_q [2];
    btn_state_e    state_d [2];
    logic [TW-1:0] tmr_q   [2];
    logic [TW-1:0] tmr_d   [2];
    logic [7:0]    ratio_q, ratio_d;
    logic          chg_q, chg_d;
    logic          lim_q, lim_d;

    // Index 0 is the up button, index 1 the down button.
    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_up (
        .clock   (clock),
        .reset   (reset),
        .btn_i   (bus.btn_up),
        .clean_o (clean[0])
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_deb_dn (
        .clock   (clock),
        .reset   (reset),
        .btn_i   (bus.btn_down),
        .clean_o (clean[1])
    );

    always_comb begin
        step = '0;
        for (int b = 0; b < 2; b++) begin
            state_d[b] = state_q[b];
            tmr_d[b]   = tmr_q[b];
            if (!clean[b]) begin
                state_d[b] = ST_IDLE;
                tmr_d[b]   = '0;
            end else begin
                case (state_q[b])
                    ST_IDLE: begin
                        step[b]    = 1'b1;
                        state_d[b] = ST_HELD;
                        tmr_d[b]   = '0;
                    end
                    ST_HELD: begin
                        if (tmr_q[b] == HOLD_LAST) begin
                            step[b]    = 1'b1;
                            state_d[b] = ST_REPEAT;
                            tmr_d[b]   = '0;
                        end else begin
                            tmr_d[b] = tmr_q[b] + 1'b1;
                        end
                    end
                    ST_REPEAT: begin
                        if (tmr_q[b] == REP_LAST) begin
                            step[b]  = 1'b1;
                            tmr_d[b] = '0;
                        end else begin
                            tmr_d[b] = tmr_q[b] + 1'b1;
                        end
                    end
                    default: begin
                        state_d[b] = ST_IDLE;
                        tmr_d[b]   = '0;
                    end
                endcase
            end
        end
    end

    // Coincident up/down steps cancel; saturation blocks the step without a change pulse.
    always_comb begin
        ratio_d = ratio_q;
        if (step[0] && !step[1] && (ratio_q < RATIO_MAX)) begin
            ratio_d = ratio_q + 8'd1;
        end else if (step[1] && !step[0] && (ratio_q > RATIO_MIN)) begin
            ratio_d = ratio_q - 8'd1;
        end
        chg_d = (ratio_d != ratio_q);
        lim_d = is_limit(ratio_d, RATIO_MIN, RATIO_MAX);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= ST_IDLE;
                tmr_q[b]   <= '0;
            end
            ratio_q <= RATIO_RESET;
            chg_q   <= 1'b0;
            lim_q   <= is_limit(RATIO_RESET, RATIO_MIN, RATIO_MAX);
        end else begin
            for (int b = 0; b < 2; b++) begin
                state_q[b] <= state_d[b];
                tmr_q[b]   <= tmr_d[b];
            end
            ratio_q <= ratio_d;
            chg_q   <= chg_d;
            lim_q   <= lim_d;
        end
    end

    assign bus.div_ratio = ratio_q;
    assign bus.ratio_chg = chg_q;
    assign bus.at_limit  = lim_q;
endmodule

// File: tb/tb_freq_sel_ctrl.sv
// Directed bench for freq_sel_ctrl with a small LED divider model hung off div_ratio.
module tb_freq_sel_ctrl;
    logic clock;
    logic reset;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   chg_cnt  = 0;
    int   chg_base;
    int   div_cnt;
    logic diode;
    int   period;

    freq_sel_ctrl_if bus ();

    freq_sel_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .HOLD_CYCLES     (16),
        .REPEAT_CYCLES   (8),
        .RATIO_RESET     (8'h05),
        .RATIO_MIN       (8'h01),
        .RATIO_MAX       (8'hFF)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (bus.ratio_chg === 1'b1) chg_cnt = chg_cnt + 1;
    end

    // Downstream LED divider: diode toggles every div_ratio cycles, so its period is 2*div_ratio.
    always @(posedge clock) begin
        if (reset) begin
            div_cnt <= 0;
            diode   <= 1'b0;
        end else if (div_cnt >= int'(bus.div_ratio) - 1) begin
            div_cnt <= 0;
            diode   <= ~diode;
        end else begin
            div_cnt <= div_cnt + 1;
        end
    end

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic measure_period(output int p);
        logic prev;
        bit   found;
        int   n;
        p     = 0;
        found = 1'b0;
        prev  = diode;
        for (int i = 0; i < 200 && !found; i++) begin
            tick();
            if (diode && !prev) found = 1'b1;
            prev = diode;
        end
        if (found) begin
            found = 1'b0;
            n     = 0;
            for (int i = 0; i < 200 && !found; i++) begin
                tick();
                n++;
                if (diode && !prev) found = 1'b1;
                prev = diode;
            end
            if (found) p = n;
        end
    endtask

    function automatic logic [7:0] down_exp(input int e);
        if (e >= 39) return 8'h01;
        if (e >= 31) return 8'h02;
        if (e >= 23) return 8'h03;
        if (e >= 7)  return 8'h04;
        return 8'h05;
    endfunction

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b1;
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        ticks(2);
        check_val("rst_div", bus.div_ratio, 8'h05);
        check_val("rst_chg", bus.ratio_chg, 1'b0);
        check_val("rst_lim", bus.at_limit, 1'b0);

        // Idle after reset release.
        reset    = 1'b0;
        chg_base = chg_cnt;
        ticks(100);
        check_val("idle_div", bus.div_ratio, 8'h05);
        check_val("idle_chg_cnt", chg_cnt - chg_base, 0);
        check_val("idle_lim", bus.at_limit, 1'b0);

        // Bouncing, then a too-short pulse, then a real press.
        for (int i = 0; i < 10; i++) begin
            bus.btn_up = (i % 2 == 0);
            tick();
        end
        bus.btn_up = 1'b1;
        ticks(3);
        bus.btn_up = 1'b0;
        ticks(20);
        check_val("bounce_div", bus.div_ratio, 8'h05);
        check_val("bounce_chg_cnt", chg_cnt - chg_base, 0);
        bus.btn_up = 1'b1;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check_val("press_div", bus.div_ratio, (e >= 7) ? 8'h06 : 8'h05);
            check_val("press_chg", bus.ratio_chg, (e == 7) ? 1'b1 : 1'b0);
        end
        bus.btn_up = 1'b0;
        ticks(20);
        check_val("press_div_final", bus.div_ratio, 8'h06);
        check_val("press_chg_cnt", chg_cnt - chg_base, 1);

        // Down held through hold and auto-repeat into the lower bound.
        reset = 1'b1;
        tick();
        check_val("rst2_div", bus.div_ratio, 8'h05);
        reset        = 1'b0;
        bus.btn_down = 1'b1;
        chg_base     = chg_cnt;
        for (int e = 1; e <= 60; e++) begin
            tick();
            check_val("down_div", bus.div_ratio, down_exp(e));
            check_val("down_chg", bus.ratio_chg,
                      (e == 7 || e == 23 || e == 31 || e == 39) ? 1'b1 : 1'b0);
        end
        check_val("down_lim", bus.at_limit, 1'b1);
        check_val("down_chg_cnt", chg_cnt - chg_base, 4);
        bus.btn_down = 1'b0;
        ticks(20);

        // Both buttons raised together: coincident steps cancel.
        reset = 1'b1;
        tick();
        reset        = 1'b0;
        bus.btn_up   = 1'b1;
        bus.btn_down = 1'b1;
        chg_base     = chg_cnt;
        for (int e = 1; e <= 10; e++) begin
            tick();
            check_val("both_div", bus.div_ratio, 8'h05);
            check_val("both_chg", bus.ratio_chg, 1'b0);
        end
        bus.btn_up   = 1'b0;
        bus.btn_down = 1'b0;
        ticks(20);
        check_val("both_chg_cnt", chg_cnt - chg_base, 0);
        check_val("both_lim", bus.at_limit, 1'b0);

        // Reset pulse mid-repeat, button still held afterwards.
        reset = 1'b1;
        tick();
        reset      = 1'b0;
        bus.btn_up = 1'b1;
        ticks(34);
        check_val("rep_div_pre", bus.div_ratio, 8'h08);
        reset = 1'b1;
        tick();
        check_val("rep_rst_div", bus.div_ratio, 8'h05);
        check_val("rep_rst_chg", bus.ratio_chg, 1'b0);
        reset = 1'b0;
        for (int e = 1; e <= 7; e++) begin
            tick();
            check_val("rep_repress_div", bus.div_ratio, (e == 7) ? 8'h06 : 8'h05);
        end
        bus.btn_up = 1'b0;
        ticks(20);

        // LED divider period follows the ratio: 5 -> 0x10 by 11 steps.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        measure_period(period);
        check_val("led_period_05", period, 10);
        bus.btn_up = 1'b1;
        chg_base   = chg_cnt;
        ticks(95);
        bus.btn_up = 1'b0;
        ticks(20);
        check_val("led_div", bus.div_ratio, 8'h10);
        check_val("led_chg_cnt", chg_cnt - chg_base, 11);
        measure_period(period);
        check_val("led_period_10", period, 32);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
